conv_mac_engine: RTL and testbench

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_mac_unit.sv | 48 ++++
 rtl/conv_mac_engine.sv | 190 +++++++++++++++++++
 tb/tb_conv_mac_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution MAC engine: FSM state encoding and
// the default widths / kernel size used by conv_mac_engine and conv_mac_unit.
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DEF_DW    = 8;   // pixel width (signed)
    localparam int DEF_WW    = 8;   // weight width (signed)
    localparam int DEF_K     = 3;   // kernel dimension, K*K taps
    localparam int DEF_OUT_W = 16;  // result width (signed)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/conv_mac_unit.sv
// ---------------------------------------------------------------------------
// conv_mac_unit
// Signed multiply-accumulate slice: acc <= acc + pix * wgt when enabled.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        synchronous clear of the accumulator (wins over i_en)
//   i_en         accumulate i_pix * i_wgt this cycle
//   i_pix        signed pixel, DW bits
//   i_wgt        signed weight, WW bits
//   o_acc        signed accumulator, ACC_W bits
// ---------------------------------------------------------------------------
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int WW    = DEF_WW,
    parameter int ACC_W = DEF_DW + DEF_WW + 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [DW-1:0]    i_pix,
    input  logic signed [WW-1:0]    i_wgt,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [DW+WW-1:0]  w_prod;
    logic signed [ACC_W-1:0]  r_acc;

    // Both operands are signed, so the product is a full signed multiply.
    assign w_prod = i_pix * i_wgt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv_mac_engine.sv
// ---------------------------------------------------------------------------
// conv_mac_engine
// K x K signed convolution engine: accepts one flattened window, accumulates
// one tap per cycle against a writable kernel, presents the result with a
// valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   window handshake; in_window holds NT*DW bits,
//                         tap t = row*K+col at [t*DW +: DW]
//   kw_we/kw_addr/kw_data kernel weight write (honoured in IDLE only,
//                         addresses >= NT ignored)
//   out_valid / out_ready result handshake; out_data is OUT_W signed bits
//   busy                  high whenever the engine is not IDLE
// Build option:
//   CONV_SAT_EN           when defined, out_data saturates to the signed
//                         OUT_W range; otherwise it wraps (low OUT_W bits).
// ---------------------------------------------------------------------------
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int WW    = DEF_WW,
    parameter  int K     = DEF_K,
    parameter  int OUT_W = DEF_OUT_W,
    localparam int NT    = K * K,
    localparam int AW    = $clog2(NT),
    localparam int ACC_W = DW + WW + $clog2(NT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NT*DW-1:0]        in_window,
    input  logic                    kw_we,
    input  logic [AW-1:0]           kw_addr,
    input  logic signed [WW-1:0]    kw_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    busy
);

    // Tap counter must reach NT itself (the result-load cycle).
    localparam int CW = $clog2(NT + 1);

    state_t                   r_state, w_next;
    logic [NT*DW-1:0]         r_window;
    logic [CW-1:0]            r_tap;
    logic signed [WW-1:0]     r_wgt [NT];
    logic                     r_pend_v;
    logic [AW-1:0]            r_pend_addr;
    logic signed [WW-1:0]     r_pend_data;
    logic signed [OUT_W-1:0]  r_out;

    logic                     w_accept, w_mac_en, w_load, w_done, w_kw_ok;
    logic [AW-1:0]            w_tap_idx;
    logic signed [DW-1:0]     w_pix;
    logic signed [WW-1:0]     w_wgt;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [OUT_W-1:0]  w_narrow;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_accept  = 1'b0;
        w_mac_en  = 1'b0;
        w_load    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = MAC;
                end
            end
            MAC: begin
                // Taps 0..NT-1 accumulate; the extra cycle at NT loads the result.
                if (r_tap == CW'(NT)) begin
                    w_load = 1'b1;
                    w_next = OUT;
                end else begin
                    w_mac_en = 1'b1;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    assign w_tap_idx = w_mac_en ? AW'(r_tap) : '0;
    assign w_pix     = r_window[w_tap_idx*DW +: DW];
    assign w_wgt     = r_wgt[w_tap_idx];

    conv_mac_unit #(
        .DW    (DW),
        .WW    (WW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (w_mac_en),
        .i_pix (w_pix),
        .i_wgt (w_wgt),
        .o_acc (w_acc)
    );

    // NOTE: the window register carries no reset; it is always loaded on
    // accept before any tap reads it, so a reset would buy nothing.
    always_ff @(posedge clk) begin
        if (w_accept) r_window <= in_window;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap <= '0;
            r_out <= '0;
        end else begin
            if (w_accept)      r_tap <= '0;
            else if (w_mac_en) r_tap <= r_tap + CW'(1);
            if (w_load)        r_out <= w_narrow;
        end
    end

    assign out_data = r_out;

`ifdef CONV_SAT_EN
    generate
        if (OUT_W < ACC_W) begin : g_sat
            logic w_ovf;
            // Overflow when the bits above the OUT_W sign bit disagree with it.
            assign w_ovf    = (w_acc[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){w_acc[ACC_W-1]}});
            assign w_narrow = !w_ovf          ? w_acc[OUT_W-1:0] :
                              w_acc[ACC_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                                {1'b0, {(OUT_W-1){1'b1}}};
        end else begin : g_ext
            assign w_narrow = OUT_W'(w_acc);
        end
    endgenerate
`else
    assign w_narrow = OUT_W'(w_acc);
`endif

    // ---------------- Kernel weight store ----------------
    // A write that coincides with an accept is parked and committed when the
    // result handshake completes, so the accepted window sees the old kernel.
    assign w_kw_ok = kw_we && (r_state == IDLE) && (32'(kw_addr) < NT);

    // Weights reset to +1: the reset value is functional, not just hygiene.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) r_wgt[i] <= WW'(1);
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            if (w_kw_ok && w_accept) begin
                r_pend_v    <= 1'b1;
                r_pend_addr <= kw_addr;
                r_pend_data <= kw_data;
            end else if (w_kw_ok) begin
                r_wgt[kw_addr] <= kw_data;
            end
            if (w_done && r_pend_v) begin
                r_wgt[r_pend_addr] <= r_pend_data;
                r_pend_v           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// ---------------------------------------------------------------------------
// tb_conv_mac_engine
// Directed + randomized bench for conv_mac_engine. Two instances share all
// inputs: the default build (OUT_W=16) and a narrow one (OUT_W=8) for the
// saturate/wrap boundary. Expected results come from a sum-of-products
// reference over a model kernel array.
// ---------------------------------------------------------------------------
module tb_conv_mac_engine;

    localparam int NT = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [NT*8-1:0]   in_window;
    logic              kw_we;
    logic [3:0]        kw_addr;
    logic signed [7:0] kw_data;
    logic              out_ready;

    logic               in_ready,  out_valid,  busy;
    logic signed [15:0] out_data;
    logic               in_ready8, out_valid8, busy8;
    logic signed [7:0]  out_data8;

    int total = 0;
    int bad   = 0;
    int mw [NT];   // model kernel

    always #5 clk = ~clk;

    conv_mac_engine dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
        .kw_we(kw_we), .kw_addr(kw_addr), .kw_data(kw_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    conv_mac_engine #(.OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready8), .in_window(in_window),
        .kw_we(kw_we), .kw_addr(kw_addr), .kw_data(kw_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .busy(busy8)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference narrowing of an exact sum to a signed w-bit result.
    function automatic int narrow(input longint acc, input int w);
        longint mx = (64'sd1 <<< (w - 1)) - 1;
        longint mn = -mx - 1;
        longint r;
`ifdef CONV_SAT_EN
        r = (acc > mx) ? mx : (acc < mn) ? mn : acc;
`else
        r = acc & ((64'sd1 <<< w) - 1);
        if (r > mx) r = r - (64'sd1 <<< w);
`endif
        return int'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kw_write(input int addr, input int data);
        kw_we   = 1'b1;
        kw_addr = 4'(addr);
        kw_data = 8'(data);
        step();
        kw_we = 1'b0;
        if (addr < NT) mw[addr] = data;
    endtask

    // One full transaction: accept, count latency, check result on both
    // instances, optionally stall in OUT, then complete the handshake.
    task automatic run_window(input int pix [NT], input int hold,
                              input bit kw_at_accept, input bit kw_in_mac,
                              input string tag);
        longint acc = 0;
        int     e16, e8, cnt;
        for (int t = 0; t < NT; t++) begin
            acc += longint'(pix[t]) * longint'(mw[t]);
            in_window[t*8 +: 8] = 8'(pix[t]);
        end
        e16 = narrow(acc, 16);
        e8  = narrow(acc, 8);
        check({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        if (kw_at_accept) begin
            kw_we = 1'b1; kw_addr = 4'd0; kw_data = 8'sd5;
        end
        step();
        in_valid = 1'b0;
        kw_we    = 1'b0;
        if (kw_at_accept) mw[0] = 5;
        check({tag, ".busy"}, busy, 1);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            if (kw_in_mac && cnt == 3) begin
                kw_we = 1'b1; kw_addr = 4'd0; kw_data = 8'sd5;
            end
            step();
            kw_we = 1'b0;
            cnt++;
        end
        check({tag, ".latency"}, cnt, NT + 1);
        check({tag, ".out_data"}, out_data, e16);
        check({tag, ".out_valid8"}, out_valid8, 1);
        check({tag, ".out_data8"}, out_data8, e8);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            step();
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_data"}, out_data, e16);
            check({tag, ".hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, out_valid, 0);
        check({tag, ".in_ready_back"}, in_ready, 1);
        check({tag, ".data_kept"}, out_data, e16);
    endtask

    int pix [NT];
    int ones_seen;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_window = '0;
        kw_we = 1'b0; kw_addr = '0; kw_data = '0; out_ready = 1'b0;
        for (int t = 0; t < NT; t++) mw[t] = 1;
        step(); step();
        check("rst.out_valid", out_valid, 0);
        check("rst.out_data", out_data, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.out_data8", out_data8, 0);
        rst_n = 1'b1;
        step();

        // Reset kernel (+1), window of 2s -> 18.
        for (int t = 0; t < NT; t++) pix[t] = 2;
        run_window(pix, 0, 1'b0, 1'b0, "w2");
        check("w2.const", out_data, 18);

        // Kernel t-4: ones -> 0, ramp -> 60.
        for (int t = 0; t < NT; t++) kw_write(t, t - 4);
        for (int t = 0; t < NT; t++) pix[t] = 1;
        run_window(pix, 0, 1'b0, 1'b0, "k_ones");
        for (int t = 0; t < NT; t++) pix[t] = t;
        run_window(pix, 5, 1'b0, 1'b0, "k_ramp_stall");
        check("k_ramp.const", out_data, 60);

        // Writes during MAC are ignored; window of 1s after it.
        for (int t = 0; t < NT; t++) kw_write(t, 1);
        for (int t = 0; t < NT; t++) pix[t] = 7;
        run_window(pix, 0, 1'b0, 1'b1, "kw_mac");
        for (int t = 0; t < NT; t++) pix[t] = 1;
        run_window(pix, 0, 1'b0, 1'b0, "kw_mac_after");

        // Write in the accept cycle: this window uses old weight, next uses 5.
        for (int t = 0; t < NT; t++) pix[t] = 3;
        run_window(pix, 0, 1'b1, 1'b0, "kw_acc");
        run_window(pix, 0, 1'b0, 1'b0, "kw_acc_after");

        // Out-of-range addresses are ignored.
        kw_write(9, 77);
        kw_write(15, -3);
        for (int t = 0; t < NT; t++) pix[t] = t + 1;
        run_window(pix, 0, 1'b0, 1'b0, "kw_oob");

        // Extremes: +127 everywhere, then -128 everywhere.
        for (int t = 0; t < NT; t++) kw_write(t, 127);
        for (int t = 0; t < NT; t++) pix[t] = 127;
        run_window(pix, 0, 1'b0, 1'b0, "max");
`ifdef CONV_SAT_EN
        check("max.sat8", out_data8, 127);
`else
        check("max.wrap8", out_data8, 9);
`endif
        for (int t = 0; t < NT; t++) kw_write(t, -128);
        for (int t = 0; t < NT; t++) pix[t] = -128;
        run_window(pix, 0, 1'b0, 1'b0, "minmin");
        for (int t = 0; t < NT; t++) pix[t] = 127;
        run_window(pix, 1, 1'b0, 1'b0, "neg");

        // Randomized kernels and windows.
        for (int n = 0; n < 6; n++) begin
            for (int t = 0; t < NT; t++) kw_write(t, int'($urandom_range(255)) - 128);
            for (int t = 0; t < NT; t++) pix[t] = int'($urandom_range(255)) - 128;
            run_window(pix, int'($urandom_range(2)), 1'b0, 1'b0, "rand");
        end

        // Reset while at MAC tap 4: window abandoned, kernel back to +1.
        for (int t = 0; t < NT; t++) in_window[t*8 +: 8] = 8'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst.out_valid", out_valid, 0);
        check("mid_rst.busy", busy, 0);
        step();
        rst_n = 1'b1;
        for (int t = 0; t < NT; t++) mw[t] = 1;
        ones_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) ones_seen++;
        end
        check("mid_rst.no_result", ones_seen, 0);
        for (int t = 0; t < NT; t++) pix[t] = 3;
        run_window(pix, 0, 1'b0, 1'b0, "post_rst");
        check("post_rst.const", out_data, 27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
